// File: rtl/riscy_pkg.sv
// Shared types and sizing for the integer register file and its load scoreboard.
package riscy_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  // r0 reads as zero and is never written or marked pending.
  localparam reg_addr_t REG_ZERO = '0;

endpackage : riscy_pkg

// File: rtl/id_regfile_load_scoreboard.sv
// Load-use scoreboard: one pending bit per GPR, set when ID issues a load and
// cleared when write-back retires a result to that register.
module load_scoreboard
  import riscy_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      wb_en,
  input  reg_addr_t wb_addr,
  input  logic      issue_load,
  input  reg_addr_t issue_dest,
  input  reg_addr_t rs_addr,
  input  reg_addr_t rt_addr,
  output logic      stall
);

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;

  // Hazard decode against the current pending state; a same-cycle WB clear
  // does not mask it, the bypass covers the cycle after.
  assign stall = pending[rs_addr] | pending[rt_addr];

  // One-hot set/clear requests for this edge; a load issued while stalled is ignored.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_load && !stall && issue_dest != REG_ZERO) set_vec[issue_dest] = 1'b1;
    if (wb_en) clr_vec[wb_addr] = 1'b1;
  end

  // Pending bits update; set is applied after clear so a newer load wins.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_vec) | set_vec;
  end

endmodule : load_scoreboard

// File: rtl/id_regfile.sv
// ID-stage register file: WB write port, two registered read ports with
// WB-to-ID write-through bypass, and the load-use stall flag.
module id_regfile
  import riscy_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      WBEn,
  input  reg_addr_t WBAddr,
  input  word_t     WBData,
  input  logic      Hold,
  input  reg_addr_t RsAddr,
  input  reg_addr_t RtAddr,
  input  logic      IssueLoad,
  input  reg_addr_t IssueDest,
  output word_t     RsData,
  output word_t     RtData,
  output logic      Stall
);

  word_t regs [NREGS];
  logic  wb_write;
  word_t rs_next;
  word_t rt_next;

  assign wb_write = WBEn && (WBAddr != REG_ZERO);

  // Architectural register storage; writes to r0 are dropped.
  // NOTE: the array is reset because the architecture defines every GPR as zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_write) begin
      regs[WBAddr] <= WBData;
    end
  end

  // Read mux: r0 forces zero, otherwise a same-edge WB write overrides the stored entry.
  always_comb begin
    rs_next = regs[RsAddr];
    rt_next = regs[RtAddr];
    if (wb_write && WBAddr == RsAddr) rs_next = WBData;
    if (wb_write && WBAddr == RtAddr) rt_next = WBData;
    if (RsAddr == REG_ZERO) rs_next = '0;
    if (RtAddr == REG_ZERO) rt_next = '0;
  end

  // Registered read outputs, frozen while ID is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      RsData <= '0;
      RtData <= '0;
    end else if (!Hold) begin
      RsData <= rs_next;
      RtData <= rt_next;
    end
  end

  load_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wb_en      (WBEn),
    .wb_addr    (WBAddr),
    .issue_load (IssueLoad),
    .issue_dest (IssueDest),
    .rs_addr    (RsAddr),
    .rt_addr    (RtAddr),
    .stall      (Stall)
  );

endmodule : id_regfile

// File: tb/tb_id_regfile.sv
// Directed bench for id_regfile: reset, write/read, bypass, r0, load-use
// scoreboard, set/clear priority, reset mid-stall and hold.
module tb_id_regfile;
  import riscy_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      WBEn;
  reg_addr_t WBAddr;
  word_t     WBData;
  logic      Hold;
  reg_addr_t RsAddr;
  reg_addr_t RtAddr;
  logic      IssueLoad;
  reg_addr_t IssueDest;
  word_t     RsData;
  word_t     RtData;
  logic      Stall;

  int n_checks = 0;
  int n_fail   = 0;

  id_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .WBEn      (WBEn),
    .WBAddr    (WBAddr),
    .WBData    (WBData),
    .Hold      (Hold),
    .RsAddr    (RsAddr),
    .RtAddr    (RtAddr),
    .IssueLoad (IssueLoad),
    .IssueDest (IssueDest),
    .RsData    (RsData),
    .RtData    (RtData),
    .Stall     (Stall)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    WBEn = 1'b0; WBAddr = '0; WBData = '0; Hold = 1'b0;
    IssueLoad = 1'b0; IssueDest = '0; RsAddr = '0; RtAddr = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    // Write and load issue during the reset edge must be discarded.
    WBEn = 1'b1; WBAddr = 5'd4; WBData = 32'hCAFE_F00D;
    IssueLoad = 1'b1; IssueDest = 5'd4;
    tick();
    rst = 1'b0;
    idle_inputs();
    n_checks++;
    if (RsData !== 32'h0 || RtData !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: RsData=%h RtData=%h, required 0", RsData, RtData);
    end
    for (int r = 1; r < 32; r++) begin
      RsAddr = reg_addr_t'(r);
      RtAddr = reg_addr_t'(32 - r);
      #1;
      n_checks++;
      if (Stall !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_stall r%0d: Stall=%b, required 0", r, Stall);
      end
      tick();
      n_checks++;
      if (RsData !== 32'h0 || RtData !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read r%0d: RsData=%h RtData=%h, required 0", r, RsData, RtData);
      end
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    WBEn = 1'b1; WBAddr = 5'd5; WBData = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    RsAddr = 5'd5; RtAddr = 5'd5;
    tick();
    n_checks++;
    if (RsData !== 32'hDEAD_BEEF || RtData !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL write_read: RsData=%h RtData=%h, required deadbeef", RsData, RtData);
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    WBEn = 1'b1; WBAddr = 5'd7; WBData = 32'h0000_1234;
    RtAddr = 5'd7; RsAddr = 5'd5;
    tick();
    n_checks++;
    if (RtData !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL bypass_rt: RtData=%h, required 00001234", RtData);
    end
    n_checks++;
    if (RsData !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL bypass_rs_other: RsData=%h, required deadbeef", RsData);
    end
    // Same rule on Rs, and the write must have landed in storage too.
    WBAddr = 5'd8; WBData = 32'h0BAD_F00D; RsAddr = 5'd8; RtAddr = 5'd7;
    tick();
    n_checks++;
    if (RsData !== 32'h0BAD_F00D || RtData !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL bypass_rs: RsData=%h RtData=%h, required 0badf00d 00001234", RsData, RtData);
    end
  endtask

  task automatic test_r0();
    idle_inputs();
    WBEn = 1'b1; WBAddr = 5'd0; WBData = 32'hFFFF_FFFF;
    RsAddr = 5'd0; RtAddr = 5'd0;
    tick();
    n_checks++;
    if (RsData !== 32'h0 || RtData !== 32'h0) begin
      n_fail++;
      $display("FAIL r0_bypass: RsData=%h RtData=%h, required 0", RsData, RtData);
    end
    WBEn = 1'b0;
    tick();
    n_checks++;
    if (RsData !== 32'h0) begin
      n_fail++;
      $display("FAIL r0_store: RsData=%h, required 0", RsData);
    end
  endtask

  task automatic test_load_use();
    idle_inputs();
    IssueLoad = 1'b1; IssueDest = 5'd9;
    tick();
    IssueLoad = 1'b0;
    RsAddr = 5'd9;
    #1;
    n_checks++;
    if (Stall !== 1'b1) begin
      n_fail++;
      $display("FAIL load_use_stall: Stall=%b, required 1", Stall);
    end
    // WB retires r9; a load issued this stalled cycle must be dropped.
    WBEn = 1'b1; WBAddr = 5'd9; WBData = 32'hA5A5_A5A5;
    IssueLoad = 1'b1; IssueDest = 5'd10;
    #1;
    n_checks++;
    if (Stall !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_unmasked: Stall=%b, required 1", Stall);
    end
    tick();
    idle_inputs();
    RsAddr = 5'd9;
    #1;
    n_checks++;
    if (Stall !== 1'b0 || RsData !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL load_use_release: Stall=%b RsData=%h, required 0 a5a5a5a5", Stall, RsData);
    end
    RtAddr = 5'd10;
    #1;
    n_checks++;
    if (Stall !== 1'b0) begin
      n_fail++;
      $display("FAIL issue_while_stalled: Stall=%b, required 0", Stall);
    end
    tick();
  endtask

  task automatic test_set_clear_same();
    idle_inputs();
    IssueLoad = 1'b1; IssueDest = 5'd3;
    WBEn = 1'b1; WBAddr = 5'd3; WBData = 32'h0000_0033;
    tick();
    idle_inputs();
    RtAddr = 5'd3;
    #1;
    n_checks++;
    if (Stall !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins: Stall=%b, required 1", Stall);
    end
    tick();
    n_checks++;
    if (RtData !== 32'h0000_0033) begin
      n_fail++;
      $display("FAIL set_wins_data: RtData=%h, required 00000033", RtData);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (Stall !== 1'b0 || RsData !== 32'h0 || RtData !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_stall: Stall=%b RsData=%h RtData=%h, required 0 0 0", Stall, RsData, RtData);
    end
    RsAddr = 5'd9;
    tick();
    n_checks++;
    if (RtData !== 32'h0 || RsData !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cleared_regs: RsData=%h RtData=%h, required 0", RsData, RtData);
    end
  endtask

  task automatic test_hold();
    idle_inputs();
    WBEn = 1'b1; WBAddr = 5'd12; WBData = 32'h1111_1111;
    tick();
    idle_inputs();
    RsAddr = 5'd12;
    tick();
    n_checks++;
    if (RsData !== 32'h1111_1111) begin
      n_fail++;
      $display("FAIL hold_setup: RsData=%h, required 11111111", RsData);
    end
    Hold = 1'b1; RsAddr = 5'd0;
    tick();
    n_checks++;
    if (RsData !== 32'h1111_1111) begin
      n_fail++;
      $display("FAIL hold_addr_change: RsData=%h, required 11111111", RsData);
    end
    RsAddr = 5'd13; WBEn = 1'b1; WBAddr = 5'd13; WBData = 32'h2222_2222;
    tick();
    n_checks++;
    if (RsData !== 32'h1111_1111) begin
      n_fail++;
      $display("FAIL hold_with_write: RsData=%h, required 11111111", RsData);
    end
    Hold = 1'b0; WBEn = 1'b0;
    tick();
    n_checks++;
    if (RsData !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL hold_release: RsData=%h, required 22222222", RsData);
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int r = 20; r < 24; r++) begin
      WBEn = 1'b1; WBAddr = reg_addr_t'(r); WBData = 32'h100 + r;
      RsAddr = reg_addr_t'(r); RtAddr = reg_addr_t'(r - 1);
      tick();
      n_checks++;
      if (RsData !== 32'(32'h100 + r) || RtData !== ((r == 20) ? 32'h0 : 32'(32'h100 + r - 1))) begin
        n_fail++;
        $display("FAIL back_to_back r%0d: RsData=%h RtData=%h", r, RsData, RtData);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_r0();
    test_load_use();
    test_set_clear_same();
    test_hold();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_id_regfile
